// File: rtl/ysyx_24110006_ibuf_if.sv
// Fetch-to-decode packet channel of the instruction buffer: IFU push side, IDU pop side,
// redirect flush and occupancy.
interface ysyx_24110006_ibuf_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          i_valid;
  logic          o_ready;
  logic [31:0]   i_inst;
  logic [31:0]   i_pc;
  logic          i_exception;
  logic [3:0]    i_mcause;
  logic          o_valid;
  logic          i_ready;
  logic [31:0]   o_inst;
  logic [31:0]   o_pc;
  logic          o_exception;
  logic [3:0]    o_mcause;
  logic          i_flush;
  logic [CW-1:0] o_count;

  modport slave (
    input  i_valid, i_inst, i_pc, i_exception, i_mcause, i_ready, i_flush,
    output o_ready, o_valid, o_inst, o_pc, o_exception, o_mcause, o_count
  );

  modport master (
    output i_valid, i_inst, i_pc, i_exception, i_mcause, i_ready, i_flush,
    input  o_ready, o_valid, o_inst, o_pc, o_exception, o_mcause, o_count
  );
endinterface

// File: rtl/ysyx_24110006_ibuf.sv
// Instruction buffer: circular FIFO of {exception, mcause, pc, inst} packets between IFU and IDU,
// emptied in one cycle by a redirect flush.
module ysyx_24110006_ibuf #(
  parameter int unsigned DEPTH = 4
) (
  input logic                  i_clock,
  input logic                  i_reset,
  ysyx_24110006_ibuf_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 69;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [EW-1:0] entry_in;

  always_comb begin
    empty    = (rd_ptr_q == wr_ptr_q);
    // Same index with differing wrap bits means the writer has lapped the reader.
    full     = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
    // Ready is a function of state only, so a full buffer rejects even when popping.
    bus.o_ready = ~full & ~i_reset;
    bus.o_valid = ~empty;
    push     = bus.i_valid & bus.o_ready & ~bus.i_flush;
    pop      = bus.o_valid & bus.i_ready & ~bus.i_flush;
    entry_in = {bus.i_exception, bus.i_mcause, bus.i_pc, bus.i_inst};
    head     = bus.o_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    bus.o_exception = head[68];
    bus.o_mcause    = head[67:64];
    bus.o_pc        = head[63:32];
    bus.o_inst      = head[31:0];
    bus.o_count     = wr_ptr_q - rd_ptr_q;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge i_clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= entry_in;
  end
endmodule

// File: doc/ysyx_24110006_ibuf.md
# ysyx_24110006_ibuf

Instruction buffer between the fetch stage (IFU/ICACHE) and the decode stage (IDU) in the pipelined core. It queues fetched instruction packets (instruction, PC, fetch-exception flag, mcause) in a small circular FIFO. This decouples IFU refill latency from IDU stalls. A flush from the redirect logic empties it in one cycle.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- CW, $clog2(DEPTH)+1: width of the occupancy output; derived, not overridden.

- i_clock  in  1  core clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  IFU packet valid.
- o_ready  out  1  buffer accepts a packet this cycle.
- i_inst  in  32  fetched instruction.
- i_pc  in  32  PC of i_inst.
- i_exception  in  1  fetch fault on this packet (e.g. AXI rresp error).
- i_mcause  in  4  exception cause, meaningful only when i_exception=1.
- o_valid  out  1  head packet valid toward IDU.
- i_ready  in  1  IDU consumes the head packet this cycle.
- o_inst  out  32  head instruction.
- o_pc  out  32  head PC.
- o_exception  out  1  head exception flag.
- o_mcause  out  4  head cause.
- i_flush  in  1  discard all entries (branch/trap redirect).
- o_count  out  CW  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH entries of 69 bits ({exception, mcause, pc, inst}); not reset.
- Pointers: rd_ptr and wr_ptr, each log2(DEPTH)+1 bits (index plus wrap bit).
- Empty when the pointers are equal. Full when the indices are equal and the wrap bits differ.
- o_count = wr_ptr − rd_ptr, modulo 2^(log2(DEPTH)+1).
- push = i_valid & o_ready & ~i_flush: writes the entry at wr_ptr index, then wr_ptr+1.
- pop = o_valid & i_ready & ~i_flush: rd_ptr+1.
- Push and pop may occur in the same cycle; occupancy is then unchanged.
- o_ready = ~full & ~i_reset. It depends only on state and reset, never on i_ready, so there is no combinational ready path.
- Because o_ready depends only on state, a full buffer never accepts a packet, even when a pop occurs in the same cycle.
- o_valid = ~empty. There is no empty bypass: a packet pushed in cycle N is visible at the output no earlier than cycle N+1.
- Head outputs (o_inst, o_pc, o_exception, o_mcause) read combinationally from the entry at rd_ptr index. They are forced to 0 when o_valid=0.
- i_flush: at the next edge both pointers return to 0, and any push or pop in that cycle is discarded. i_flush has priority over push and pop.
- Pointer arithmetic wraps naturally at 2^(log2(DEPTH)+1); there are no special cases at index wrap-around.
- i_exception packets are stored and forwarded like any other packet; the buffer does not interpret them.

## Timing
- Reset is asynchronous. The block is held in reset while i_reset=1, and a mid-operation reset drops all contents immediately.
- Output values while i_reset=1:
  - o_valid=0, o_ready=0, o_count=0.
  - o_inst=0, o_pc=0, o_exception=0, o_mcause=0.
- First cycle after i_reset falls: o_ready=1 (the buffer is empty).
- Push-to-output latency: 1 cycle.
- Back-to-back throughput: 1 packet per cycle in each direction.
- o_count and o_ready update one edge after the push or pop that changes them.
- Flush in cycle N: o_valid=0 and o_count=0 in cycle N+1. o_ready=1 in cycle N+1.
- Handshake rule: the IFU holds i_inst, i_pc, i_exception and i_mcause stable while i_valid=1 and o_ready=0. The buffer holds its head outputs stable while o_valid=1 and i_ready=0.

## Test plan
- Reset/idle: assert i_reset asynchronously mid-cycle.
  - Required while i_reset=1: o_valid=0, o_ready=0 and o_count=0, with no clock edge needed.
  - Required after release: o_ready=1 on the first cycle.
- Fill/drain, DEPTH=4, i_ready=0:
  - Push pc 0x80000000, 0x80000004, 0x80000008 and 0x8000000C.
  - Required: o_count=4 and o_ready=0; a fifth push is ignored.
  - Then hold i_ready=1. Required: the PCs appear in order on four consecutive cycles, then o_valid=0.
- Streaming: i_valid=1 and i_ready=1 continuously for 20 cycles with incrementing PCs.
  - Required: o_count stays at 1 after the first cycle.
  - Required: each PC appears exactly once, 1 cycle after its push.
  - Required: pointers cross index wrap-around with no loss.
- Simultaneous events:
  - Full, with i_valid=1 and i_ready=1: pop occurs, push is rejected, o_count becomes 3.
  - count=2, with push and pop in the same cycle: o_count stays 2 and order is preserved.
- Flush: with 3 entries, assert i_flush together with i_valid=1 and i_ready=1.
  - Required next cycle: o_valid=0 and o_count=0.
  - Required: the flushed-cycle packet is never output, and a subsequent push appears normally.
- Exception passthrough: push i_exception=1, i_mcause=4'd1, pc 0x80000010.
  - Required at the output: o_exception=1, o_mcause=1, o_pc=0x80000010.
  - Required: the following normal packet has o_exception=0.
